// File: rtl/kmer_hasher.sv
// -----------------------------------------------------------------------------
// kmer_hasher
//
// Feeds the bottom-k signature sorter. Takes a stream of 2-bit DNA bases
// (A=0, C=1, G=2, T=3), keeps a rolling k-mer, and produces one hashed
// signature plus the k-mer start index for every complete k-mer.
//
// Pipeline: kmer register -> stage 1 (seed xor + multiply) ->
// stage 2 (xor-fold) -> output. A base accepted on edge t shows up as a beat
// after edge t+2 when the consumer is ready. All stages share a single
// advance signal, so a stall at the output freezes the whole pipe.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   base_in        base code
//   base_valid     base_in is valid
//   base_ready     block accepts a base this cycle (combinational from sig_ready)
//   seq_start      accepted base is base 0 of a new sequence
//   seq_last       accepted base is the final base of the sequence
//   signature_out  k-mer hash
//   index_out      start position of the k-mer in its sequence
//   sig_valid      signature_out/index_out valid
//   sig_ready      consumer accepts the beat
//   sig_last       beat is the final k-mer of the sequence
//   short_seq      sticky: last sequence ended before a full k-mer was seen
//   index_wrap     sticky: index counter wrapped in the current sequence
// -----------------------------------------------------------------------------
module kmer_hasher #(
    parameter int          KMER_LENGTH     = 16,
    parameter int          SIGNATURE_WIDTH = 32,
    parameter int          INDEX_WIDTH     = 10,
    parameter logic [31:0] HASH_SEED       = 32'h0,
    parameter logic [31:0] HASH_MULT       = 32'h9E3779B1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 base_in,
    input  logic                       base_valid,
    output logic                       base_ready,
    input  logic                       seq_start,
    input  logic                       seq_last,
    output logic [SIGNATURE_WIDTH-1:0] signature_out,
    output logic [INDEX_WIDTH-1:0]     index_out,
    output logic                       sig_valid,
    input  logic                       sig_ready,
    output logic                       sig_last,
    output logic                       short_seq,
    output logic                       index_wrap
);

    localparam int KW    = 2 * KMER_LENGTH;
    localparam int SW    = SIGNATURE_WIDTH;
    localparam int HALF  = SIGNATURE_WIDTH / 2;
    localparam int CNT_W = $clog2(KMER_LENGTH + 1);

    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(KMER_LENGTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(KMER_LENGTH);
    localparam logic [SW-1:0]    SEED_W    = SW'(HASH_SEED);
    localparam logic [SW-1:0]    MULT_W    = SW'(HASH_MULT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM
    } state_t;

    // Sequencing state
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [KW-1:0]       kmer_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic                short_q;
    logic                wrap_q;

    // k-mer stage: kmer_q holds a fresh complete k-mer when kv_q is set
    logic                kv_q;
    logic [INDEX_WIDTH-1:0] kidx_q;
    logic                klast_q;

    // Hash stage 1
    logic                s1_valid_q;
    logic [SW-1:0]       s1_prod_q;
    logic [INDEX_WIDTH-1:0] s1_idx_q;
    logic                s1_last_q;

    // Hash stage 2 / output
    logic                s2_valid_q;
    logic [SW-1:0]       s2_sig_q;
    logic [INDEX_WIDTH-1:0] s2_idx_q;
    logic                s2_last_q;

    // Combinational helpers
    logic                adv;
    logic                accept;
    logic                emit;
    logic [KW-1:0]       kmer_shift_d;
    logic [SW-1:0]       s1_prod_d;
    logic [SW-1:0]       s2_sig_d;

    // The whole pipe moves together; it only stops when a beat is waiting
    // at the output and the consumer is not taking it.
    assign adv    = !s2_valid_q || sig_ready;
    assign accept = base_valid && adv;

    // A base completes a k-mer when it is the last fill base or we are
    // already streaming. seq_start always restarts the fill instead.
    assign emit = accept && !seq_start &&
                  ((state_q == ST_STREAM) ||
                   ((state_q == ST_FILL) && (cnt_q == LAST_FILL)));

    assign kmer_shift_d = {kmer_q[KW-3:0], base_in};
    assign s1_prod_d    = (SW'(kmer_q) ^ SEED_W) * MULT_W;
    assign s2_sig_d     = s1_prod_q ^ (s1_prod_q >> HALF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            kmer_q     <= '0;
            idx_q      <= '0;
            short_q    <= 1'b0;
            wrap_q     <= 1'b0;
            kv_q       <= 1'b0;
            kidx_q     <= '0;
            klast_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_idx_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sig_q   <= '0;
            s2_idx_q   <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            if (adv) begin
                kv_q       <= emit;
                kidx_q     <= idx_q;
                klast_q    <= emit && seq_last;
                s1_valid_q <= kv_q;
                s1_prod_q  <= s1_prod_d;
                s1_idx_q   <= kidx_q;
                s1_last_q  <= klast_q;
                s2_valid_q <= s1_valid_q;
                s2_sig_q   <= s2_sig_d;
                s2_idx_q   <= s1_idx_q;
                s2_last_q  <= s1_last_q;
            end

            if (accept) begin
                if (seq_start) begin
                    // New sequence from any state: old k-mer and flags go.
                    kmer_q <= KW'(base_in);
                    cnt_q  <= CNT_W'(1);
                    idx_q  <= '0;
                    wrap_q <= 1'b0;
                    if (seq_last) begin
                        short_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        short_q <= 1'b0;
                        state_q <= ST_FILL;
                    end
                end else begin
                    case (state_q)
                        ST_FILL: begin
                            kmer_q <= kmer_shift_d;
                            if (cnt_q == LAST_FILL) begin
                                cnt_q   <= FULL_CNT;
                                state_q <= seq_last ? ST_IDLE : ST_STREAM;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                                if (seq_last) begin
                                    short_q <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                        end
                        ST_STREAM: begin
                            kmer_q <= kmer_shift_d;
                            if (seq_last) begin
                                state_q <= ST_IDLE;
                            end
                        end
                        default: begin
                            // IDLE: bases outside a framed sequence are dropped
                        end
                    endcase
                end

                if (emit) begin
                    idx_q <= idx_q + 1'b1;
                    if (&idx_q) begin
                        wrap_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign base_ready    = adv;
    assign sig_valid     = s2_valid_q;
    assign signature_out = s2_sig_q;
    assign index_out     = s2_idx_q;
    assign sig_last      = s2_last_q;
    assign short_seq     = short_q;
    assign index_wrap    = wrap_q;

endmodule

// File: tb/tb_kmer_hasher.sv
// -----------------------------------------------------------------------------
// tb_kmer_hasher
//
// Directed bench for kmer_hasher (KMER_LENGTH=16, SIGNATURE_WIDTH=32,
// INDEX_WIDTH=3). Bases are driven #1 after the rising edge; outputs are
// sampled on the falling edge. Expected beats are pushed to a queue when the
// completing base is accepted and popped when the DUT hands the beat over.
// -----------------------------------------------------------------------------
module tb_kmer_hasher;

    logic        clock;
    logic        reset;
    logic [1:0]  base_in;
    logic        base_valid;
    logic        base_ready;
    logic        seq_start;
    logic        seq_last;
    logic [31:0] signature_out;
    logic [2:0]  index_out;
    logic        sig_valid;
    logic        sig_ready;
    logic        sig_last;
    logic        short_seq;
    logic        index_wrap;

    int total  = 0;
    int bad    = 0;
    int nbeats = 0;

    // Scoreboard entry: {signature[31:0], index[2:0], last}
    logic [35:0] exp_q[$];

    // Reference model state
    logic [31:0] m_kmer;
    int          m_cnt;
    bit          m_active;
    logic [2:0]  m_idx;

    // Stall tracking for output stability
    bit          prev_stall;
    logic [31:0] held_sig;
    logic [2:0]  held_idx;
    logic        held_last;

    kmer_hasher #(
        .KMER_LENGTH     (16),
        .SIGNATURE_WIDTH (32),
        .INDEX_WIDTH     (3),
        .HASH_SEED       (32'h0),
        .HASH_MULT       (32'h9E3779B1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .base_in       (base_in),
        .base_valid    (base_valid),
        .base_ready    (base_ready),
        .seq_start     (seq_start),
        .seq_last      (seq_last),
        .signature_out (signature_out),
        .index_out     (index_out),
        .sig_valid     (sig_valid),
        .sig_ready     (sig_ready),
        .sig_last      (sig_last),
        .short_seq     (short_seq),
        .index_wrap    (index_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_hash(input logic [31:0] k);
        logic [31:0] p;
        p = k * 32'h9E3779B1;
        return p ^ (p >> 16);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one base and wait (bounded) for it to be accepted; update model.
    task automatic send_base(input logic [1:0] b, input logic st, input logic ls);
        int  n;
        bit  acc;
        n   = 0;
        acc = 0;
        base_in    = b;
        base_valid = 1'b1;
        seq_start  = st;
        seq_last   = ls;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = base_ready;
            @(posedge clock);
            #1;
            n++;
        end
        base_valid = 1'b0;
        seq_start  = 1'b0;
        seq_last   = 1'b0;
        check("base_accept", 64'(acc), 64'(1));
        if (acc) begin
            if (st) begin
                m_kmer   = {30'b0, b};
                m_cnt    = 1;
                m_idx    = 3'd0;
                m_active = !ls;
            end else if (m_active) begin
                m_kmer = {m_kmer[29:0], b};
                m_cnt++;
                if (m_cnt >= 16) begin
                    exp_q.push_back({ref_hash(m_kmer), m_idx, ls});
                    m_idx = m_idx + 3'd1;
                end
                if (ls) m_active = 0;
            end
        end
        $display("base b=%0d start=%0d last=%0d accepted=%0d", b, st, ls, acc);
    endtask

    // Wait (bounded) for a beat being handed over; return its fields.
    task automatic wait_beat(output logic [31:0] s, output logic [2:0] i, output logic l);
        bit seen;
        seen = 0;
        s = '0;
        i = '0;
        l = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            if (sig_valid && sig_ready) begin
                seen = 1;
                s = signature_out;
                i = index_out;
                l = sig_last;
            end
        end
        check("beat_timeout", 64'(seen), 64'(1));
    endtask

    // Output monitor: scoreboard compare and stall stability.
    always @(negedge clock) begin
        logic [35:0] e;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(sig_valid), 64'(1));
                check("stall_sig", 64'(signature_out), 64'(held_sig));
                check("stall_idx", 64'(index_out), 64'(held_idx));
                check("stall_last", 64'(sig_last), 64'(held_last));
            end
            if (sig_valid && sig_ready) begin
                nbeats++;
                $display("beat sig=%08h idx=%0d last=%0d", signature_out, index_out, sig_last);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat_sig", 64'(signature_out), 64'(e[35:4]));
                    check("beat_idx", 64'(index_out), 64'(e[3:1]));
                    check("beat_last", 64'(sig_last), 64'(e[0]));
                end
            end
            prev_stall = sig_valid && !sig_ready;
            held_sig   = signature_out;
            held_idx   = index_out;
            held_last  = sig_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [2:0]  i;
        logic        l;
        int          nb0;

        reset      = 1'b1;
        base_in    = 2'd0;
        base_valid = 1'b0;
        seq_start  = 1'b0;
        seq_last   = 1'b0;
        sig_ready  = 1'b1;
        m_kmer     = '0;
        m_cnt      = 0;
        m_active   = 0;
        m_idx      = '0;
        prev_stall = 0;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_sig_valid", 64'(sig_valid), 64'(0));
        check("rst_signature", 64'(signature_out), 64'(0));
        check("rst_index", 64'(index_out), 64'(0));
        check("rst_sig_last", 64'(sig_last), 64'(0));
        check("rst_short_seq", 64'(short_seq), 64'(0));
        check("rst_index_wrap", 64'(index_wrap), 64'(0));
        check("rst_base_ready", 64'(base_ready), 64'(1));
        @(posedge clock);
        #1;

        // Bases outside a sequence are dropped.
        send_base(2'd3, 1'b0, 1'b0);

        // 1: sixteen A bases -> one beat two cycles after the 16th base.
        nb0 = nbeats;
        send_base(2'd0, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) send_base(2'd0, 1'b0, 1'b0);
        @(negedge clock);
        check("lat_cycle1", 64'(sig_valid), 64'(0));
        @(negedge clock);
        check("lat_cycle2", 64'(sig_valid), 64'(0));
        @(negedge clock);
        check("lat_cycle3", 64'(sig_valid), 64'(1));
        check("allA_sig", 64'(signature_out), 64'(32'h0));
        check("allA_idx", 64'(index_out), 64'(0));
        repeat (3) @(negedge clock);
        check("allA_nbeats", 64'(nbeats - nb0), 64'(1));

        // 2: fifteen A then C, then one more A.
        @(posedge clock);
        #1;
        send_base(2'd0, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) send_base(2'd0, 1'b0, 1'b0);
        send_base(2'd1, 1'b0, 1'b0);
        wait_beat(s, i, l);
        check("c_sig", 64'(s), 64'(32'h9E37E786));
        check("c_idx", 64'(i), 64'(0));
        @(posedge clock);
        #1;
        send_base(2'd0, 1'b0, 1'b0);
        wait_beat(s, i, l);
        check("ca_sig", 64'(s), 64'(32'h78DD9E19));
        check("ca_idx", 64'(i), 64'(1));
        @(posedge clock);
        #1;

        // 3: 20-base sequence with a 5-cycle stall mid-stream.
        nb0 = nbeats;
        send_base(2'($urandom_range(0, 3)), 1'b1, 1'b0);
        for (int k = 1; k < 17; k++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        fork
            begin
                send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
                send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
                send_base(2'($urandom_range(0, 3)), 1'b0, 1'b1);
            end
            begin
                sig_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 sig_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clock);
        #1;
        check("stall_nbeats", 64'(nbeats - nb0), 64'(5));
        check("stall_queue", 64'(exp_q.size()), 64'(0));

        // 4: short sequence sets short_seq; next seq_start clears it.
        nb0 = nbeats;
        send_base(2'd2, 1'b1, 1'b0);
        for (int k = 1; k < 6; k++) send_base(2'd1, 1'b0, 1'b0);
        send_base(2'd3, 1'b0, 1'b1);
        check("short_set", 64'(short_seq), 64'(1));
        repeat (5) @(posedge clock);
        #1;
        check("short_nbeats", 64'(nbeats - nb0), 64'(0));
        send_base(2'd0, 1'b1, 1'b0);
        check("short_clear", 64'(short_seq), 64'(0));
        send_base(2'd1, 1'b1, 1'b1);
        check("one_base_short", 64'(short_seq), 64'(1));

        // 5: 25-base sequence, index counter wraps at 8.
        nb0 = nbeats;
        send_base(2'($urandom_range(0, 3)), 1'b1, 1'b0);
        for (int k = 1; k < 17; k++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        check("wrap_early", 64'(index_wrap), 64'(0));
        for (int k = 17; k < 24; k++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        send_base(2'($urandom_range(0, 3)), 1'b0, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("wrap_set", 64'(index_wrap), 64'(1));
        check("wrap_nbeats", 64'(nbeats - nb0), 64'(10));

        // 6: reset with two beats in flight and the consumer stalled.
        sig_ready = 1'b0;
        send_base(2'd1, 1'b1, 1'b0);
        check("wrap_clear", 64'(index_wrap), 64'(0));
        for (int k = 1; k < 17; k++) send_base(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("inflight_valid", 64'(sig_valid), 64'(1));
        nb0 = nbeats;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(sig_valid), 64'(0));
        check("async_rst_ready", 64'(base_ready), 64'(1));
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        m_active  = 0;
        sig_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("post_rst_nbeats", 64'(nbeats - nb0), 64'(0));
        check("post_rst_valid", 64'(sig_valid), 64'(0));
        check("final_queue", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
